// File: rtl/rgb888_to_gray_stats_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rgb888_to_gray_stats_if : RGB888 video in, luma video out, frame stats   |
// | Revision : 1.0                                                           |
// +------------------------------------------------------------------------+
interface rgb888_to_gray_stats_if #(
  parameter int CNT_W = 22
);
  logic [7:0]       Pre_R;
  logic [7:0]       Pre_G;
  logic [7:0]       Pre_B;
  logic             Pre_DE;
  logic             Pre_Vsync;
  logic             Pre_Hsync;
  logic             Post_DE;
  logic             Post_Vsync;
  logic             Post_Hsync;
  logic [7:0]       Post_Gray;
  logic [7:0]       Frame_Luma_Min;
  logic [7:0]       Frame_Luma_Max;
  logic [CNT_W-1:0] Frame_Pix_Cnt;
  logic [CNT_W-1:0] Frame_Bright_Cnt;
  logic             Frame_Stat_Valid;

  modport master (
    output Pre_R, Pre_G, Pre_B, Pre_DE, Pre_Vsync, Pre_Hsync,
    input  Post_DE, Post_Vsync, Post_Hsync, Post_Gray,
    input  Frame_Luma_Min, Frame_Luma_Max, Frame_Pix_Cnt, Frame_Bright_Cnt,
    input  Frame_Stat_Valid
  );

  modport slave (
    input  Pre_R, Pre_G, Pre_B, Pre_DE, Pre_Vsync, Pre_Hsync,
    output Post_DE, Post_Vsync, Post_Hsync, Post_Gray,
    output Frame_Luma_Min, Frame_Luma_Max, Frame_Pix_Cnt, Frame_Bright_Cnt,
    output Frame_Stat_Valid
  );
endinterface
`default_nettype wire

// File: rtl/rgb888_to_gray_stats.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rgb888_to_gray_stats : 3-stage RGB888->luma pipeline with optional      |
// | per-frame min/max/count statistics (macro GRAY_FRAME_STATS_EN).         |
// | Revision : 1.0                                                           |
// +------------------------------------------------------------------------+
module rgb888_to_gray_stats #(
  parameter logic [7:0] BRIGHT_THR = 8'd200,
  parameter int         CNT_W      = 22
) (
  input  wire logic             Pre_clk,
  input  wire logic             Pre_Rst,
  rgb888_to_gray_stats_if.slave vif
);

  logic [15:0] r_prod_r;
  logic [15:0] r_prod_g;
  logic [15:0] r_prod_b;
  logic [15:0] r_sum;
  logic [2:0]  r_tim_s1;
  logic [2:0]  r_tim_s2;

  // Timing travels as {DE, Vsync, Hsync} alongside the data stages
  always_ff @(posedge Pre_clk or posedge Pre_Rst) begin
    if (Pre_Rst) begin
      r_prod_r       <= 16'd0;
      r_prod_g       <= 16'd0;
      r_prod_b       <= 16'd0;
      r_sum          <= 16'd0;
      r_tim_s1       <= 3'd0;
      r_tim_s2       <= 3'd0;
      vif.Post_Gray  <= 8'd0;
      vif.Post_DE    <= 1'b0;
      vif.Post_Vsync <= 1'b0;
      vif.Post_Hsync <= 1'b0;
    end else begin
      r_prod_r       <= 16'(vif.Pre_R) * 16'd77;
      r_prod_g       <= 16'(vif.Pre_G) * 16'd150;
      r_prod_b       <= 16'(vif.Pre_B) * 16'd29;
      r_tim_s1       <= {vif.Pre_DE, vif.Pre_Vsync, vif.Pre_Hsync};
      r_sum          <= r_prod_r + r_prod_g + r_prod_b + 16'd128;
      r_tim_s2       <= r_tim_s1;
      vif.Post_Gray  <= 8'(r_sum >> 8);
      vif.Post_DE    <= r_tim_s2[2];
      vif.Post_Vsync <= r_tim_s2[1];
      vif.Post_Hsync <= r_tim_s2[0];
    end
  end

`ifdef GRAY_FRAME_STATS_EN
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_vsync_d;
  logic [7:0]       r_run_min;
  logic [7:0]       r_run_max;
  logic [CNT_W-1:0] r_run_pix;
  logic [CNT_W-1:0] r_run_bright;
  logic             w_boundary;
  logic [7:0]       w_base_min;
  logic [7:0]       w_base_max;
  logic [CNT_W-1:0] w_base_pix;
  logic [CNT_W-1:0] w_base_bright;
  logic [7:0]       w_next_min;
  logic [7:0]       w_next_max;
  logic [CNT_W-1:0] w_next_pix;
  logic [CNT_W-1:0] w_next_bright;

  always_comb begin
    w_boundary    = vif.Post_Vsync & ~r_vsync_d;
    // A pixel on the boundary cycle starts the new frame from the initial values
    w_base_min    = w_boundary ? 8'hFF : r_run_min;
    w_base_max    = w_boundary ? 8'h00 : r_run_max;
    w_base_pix    = w_boundary ? '0 : r_run_pix;
    w_base_bright = w_boundary ? '0 : r_run_bright;
    w_next_min    = w_base_min;
    w_next_max    = w_base_max;
    w_next_pix    = w_base_pix;
    w_next_bright = w_base_bright;
    if (vif.Post_DE) begin
      if (vif.Post_Gray < w_base_min) w_next_min = vif.Post_Gray;
      if (vif.Post_Gray > w_base_max) w_next_max = vif.Post_Gray;
      if (w_base_pix != '1) w_next_pix = w_base_pix + c_CNT_ONE;
      if ((vif.Post_Gray > BRIGHT_THR) && (w_base_bright != '1))
        w_next_bright = w_base_bright + c_CNT_ONE;
    end
  end

  always_ff @(posedge Pre_clk or posedge Pre_Rst) begin
    if (Pre_Rst) begin
      r_vsync_d            <= 1'b0;
      r_run_min            <= 8'hFF;
      r_run_max            <= 8'h00;
      r_run_pix            <= '0;
      r_run_bright         <= '0;
      vif.Frame_Luma_Min   <= 8'hFF;
      vif.Frame_Luma_Max   <= 8'h00;
      vif.Frame_Pix_Cnt    <= '0;
      vif.Frame_Bright_Cnt <= '0;
      vif.Frame_Stat_Valid <= 1'b0;
    end else begin
      r_vsync_d            <= vif.Post_Vsync;
      r_run_min            <= w_next_min;
      r_run_max            <= w_next_max;
      r_run_pix            <= w_next_pix;
      r_run_bright         <= w_next_bright;
      vif.Frame_Stat_Valid <= w_boundary;
      if (w_boundary) begin
        vif.Frame_Luma_Min   <= r_run_min;
        vif.Frame_Luma_Max   <= r_run_max;
        vif.Frame_Pix_Cnt    <= r_run_pix;
        vif.Frame_Bright_Cnt <= r_run_bright;
      end
    end
  end
`else
  assign vif.Frame_Luma_Min   = 8'h00;
  assign vif.Frame_Luma_Max   = 8'h00;
  assign vif.Frame_Pix_Cnt    = '0;
  assign vif.Frame_Bright_Cnt = '0;
  assign vif.Frame_Stat_Valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rgb888_to_gray_stats.sv
`default_nettype none
// Bench for rgb888_to_gray_stats: vector table, frame scenarios, random traffic
// checked every cycle against a queue-based reference model.
module tb_rgb888_to_gray_stats;

`ifdef GRAY_FRAME_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif
  localparam int BRIGHT = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rgb888_to_gray_stats_if #(.CNT_W(22)) ifc ();
  rgb888_to_gray_stats_if #(.CNT_W(3))  ifs ();

  assign ifs.Pre_R     = ifc.Pre_R;
  assign ifs.Pre_G     = ifc.Pre_G;
  assign ifs.Pre_B     = ifc.Pre_B;
  assign ifs.Pre_DE    = ifc.Pre_DE;
  assign ifs.Pre_Vsync = ifc.Pre_Vsync;
  assign ifs.Pre_Hsync = ifc.Pre_Hsync;

  rgb888_to_gray_stats #(.BRIGHT_THR(8'd200), .CNT_W(22)) dut (
    .Pre_clk(clk), .Pre_Rst(rst), .vif(ifc));
  rgb888_to_gray_stats #(.BRIGHT_THR(8'd200), .CNT_W(3)) dut_sat (
    .Pre_clk(clk), .Pre_Rst(rst), .vif(ifs));

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {logic [7:0] gray; logic de; logic vs; logic hs;} post_t;
  post_t      pipe_q[$];
  post_t      m_post;
  logic       m_vsd;
  logic [7:0] frame_q[$];
  logic [7:0] e_min, e_max;
  int         e_pix, e_bright;
  logic       e_valid;

  function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int s;
    s = (77 * int'(r) + 150 * int'(g) + 29 * int'(b) + 128) / 256;
    return 8'(s);
  endfunction

  function automatic int sat(input int n, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (n > lim) ? lim : n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q.delete();
      for (int i = 0; i < 3; i++) pipe_q.push_back('0);
      m_post = '0; m_vsd = 1'b0; frame_q.delete();
      e_min = 8'hFF; e_max = 8'h00; e_pix = 0; e_bright = 0; e_valid = 1'b0;
    end else begin
      e_valid = 1'b0;
      if (m_post.vs && !m_vsd) begin
        e_min = 8'hFF; e_max = 8'h00; e_pix = frame_q.size(); e_bright = 0;
        foreach (frame_q[i]) begin
          if (frame_q[i] < e_min) e_min = frame_q[i];
          if (frame_q[i] > e_max) e_max = frame_q[i];
          if (int'(frame_q[i]) > BRIGHT) e_bright++;
        end
        e_valid = 1'b1;
        frame_q.delete();
      end
      if (m_post.de) frame_q.push_back(m_post.gray);
      m_vsd = m_post.vs;
      pipe_q.push_back({luma(ifc.Pre_R, ifc.Pre_G, ifc.Pre_B),
                        ifc.Pre_DE, ifc.Pre_Vsync, ifc.Pre_Hsync});
      void'(pipe_q.pop_front());
      m_post = pipe_q[0];
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("post_gray",  ifc.Post_Gray,  m_post.gray);
      chk("post_de",    ifc.Post_DE,    m_post.de);
      chk("post_vsync", ifc.Post_Vsync, m_post.vs);
      chk("post_hsync", ifc.Post_Hsync, m_post.hs);
      chk("frame_valid",  ifc.Frame_Stat_Valid, STATS_ON ? e_valid : 1'b0);
      chk("frame_min",    ifc.Frame_Luma_Min,   STATS_ON ? e_min : 8'h00);
      chk("frame_max",    ifc.Frame_Luma_Max,   STATS_ON ? e_max : 8'h00);
      chk("frame_pix",    ifc.Frame_Pix_Cnt,    STATS_ON ? sat(e_pix, 22) : 0);
      chk("frame_bright", ifc.Frame_Bright_Cnt, STATS_ON ? sat(e_bright, 22) : 0);
      chk("sat_gray",   ifs.Post_Gray,        m_post.gray);
      chk("sat_pix",    ifs.Frame_Pix_Cnt,    STATS_ON ? sat(e_pix, 3) : 0);
      chk("sat_bright", ifs.Frame_Bright_Cnt, STATS_ON ? sat(e_bright, 3) : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic de, input logic vs, input logic hs);
    ifc.Pre_R = r; ifc.Pre_G = g; ifc.Pre_B = b;
    ifc.Pre_DE = de; ifc.Pre_Vsync = vs; ifc.Pre_Hsync = hs;
    @(negedge clk);
  endtask

  task automatic cyc(input logic [7:0] v, input logic de, input logic vs);
    drive(v, v, v, de, vs, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, 1'b0);
  endtask

  // Called right after the cycle carrying the Vsync rise has been driven
  task automatic check_frame(input string name, input logic [7:0] x_min, input logic [7:0] x_max,
                             input int x_pix, input int x_bright, input int x_pix_s);
`ifdef GRAY_FRAME_STATS_EN
    int lat;
    lat = 0;
    while (!ifc.Frame_Stat_Valid && lat < 12) begin
      cyc(8'h00, 1'b0, 1'b0);
      lat++;
    end
    chk({name, "_latency"}, lat, 3);
    chk({name, "_min"}, ifc.Frame_Luma_Min, x_min);
    chk({name, "_max"}, ifc.Frame_Luma_Max, x_max);
    chk({name, "_pix"}, ifc.Frame_Pix_Cnt, x_pix);
    chk({name, "_bright"}, ifc.Frame_Bright_Cnt, x_bright);
    chk({name, "_sat_pix"}, ifs.Frame_Pix_Cnt, x_pix_s);
    cyc(8'h00, 1'b0, 1'b0);
    chk({name, "_pulse_width"}, ifc.Frame_Stat_Valid, 1'b0);
    chk({name, "_hold_pix"}, ifc.Frame_Pix_Cnt, x_pix);
`else
    idle(4);
    chk({name, "_off_min"}, ifc.Frame_Luma_Min, 8'h00);
    chk({name, "_off_max"}, ifc.Frame_Luma_Max, 8'h00);
    chk({name, "_off_pix"}, ifc.Frame_Pix_Cnt, 0);
    chk({name, "_off_bright"}, ifc.Frame_Bright_Cnt, 0);
    chk({name, "_off_valid"}, ifc.Frame_Stat_Valid, 1'b0);
    chk({name, "_off_sat_pix"}, ifs.Frame_Pix_Cnt, 0);
    if (0 > x_pix + x_pix_s + x_bright + int'(x_min) + int'(x_max)) idle(1);
`endif
  endtask

  typedef struct {
    logic [7:0] r, g, b;
    logic       de, vs, hs;
    logic [7:0] gray;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF};
    tbl[1] = '{8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h4D};
    tbl[2] = '{8'h00, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1, 8'h95};
    tbl[3] = '{8'h00, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h1D};
    tbl[4] = '{8'h80, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 8'h80};
    tbl[5] = '{8'h10, 8'h20, 8'h30, 1'b1, 1'b0, 1'b0, 8'h1D};
    tbl[6] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[7] = '{8'h01, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01};

    ifc.Pre_R = 0; ifc.Pre_G = 0; ifc.Pre_B = 0;
    ifc.Pre_DE = 0; ifc.Pre_Vsync = 0; ifc.Pre_Hsync = 0;
    #1 rst = 1'b1;
    @(negedge clk);
    check_en = 1'b1;
    @(negedge clk);
    chk("rst_gray",  ifc.Post_Gray, 8'h00);
    chk("rst_de",    ifc.Post_DE, 1'b0);
    chk("rst_valid", ifc.Frame_Stat_Valid, 1'b0);
    chk("rst_min",   ifc.Frame_Luma_Min, STATS_ON ? 8'hFF : 8'h00);
    chk("rst_max",   ifc.Frame_Luma_Max, 8'h00);
    chk("rst_pix",   ifc.Frame_Pix_Cnt, 0);
    #2 rst = 1'b0;
    @(negedge clk);

    // Table vectors: result of entry i appears three edges after it is driven
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].de, tbl[i].vs, tbl[i].hs);
      else       drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      if (i >= 2) begin
        chk($sformatf("tbl%0d_gray", i - 2), ifc.Post_Gray, tbl[i - 2].gray);
        chk($sformatf("tbl%0d_de", i - 2), ifc.Post_DE, tbl[i - 2].de);
        chk($sformatf("tbl%0d_vs", i - 2), ifc.Post_Vsync, tbl[i - 2].vs);
        chk($sformatf("tbl%0d_hs", i - 2), ifc.Post_Hsync, tbl[i - 2].hs);
      end
    end

    // 4-pixel frame
    idle(3);
    cyc(8'h00, 1'b0, 1'b1);
    check_frame("pre4", 8'hFF, 8'h00, 0, 0, 0);
    cyc(8'h10, 1'b1, 1'b0); cyc(8'hC8, 1'b1, 1'b0);
    cyc(8'hFF, 1'b1, 1'b0); cyc(8'h00, 1'b1, 1'b0);
    idle(2);
    cyc(8'h00, 1'b0, 1'b1);
    check_frame("four_pix", 8'h00, 8'hFF, 4, 1, 4);

    // Empty frame, then a pixel on the boundary cycle
    idle(3);
    cyc(8'h00, 1'b0, 1'b1);
    check_frame("empty", 8'hFF, 8'h00, 0, 0, 0);
    idle(2);
    cyc(8'h80, 1'b1, 1'b1);
    check_frame("empty2", 8'hFF, 8'h00, 0, 0, 0);
    idle(3);
    cyc(8'h00, 1'b0, 1'b1);
    check_frame("edge_pix", 8'h80, 8'h80, 1, 0, 1);

    // Reset in mid-frame discards the partial frame
    for (int i = 0; i < 10; i++) cyc(8'(8'h20 + i), 1'b1, 1'b0);
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_valid", ifc.Frame_Stat_Valid, 1'b0);
      chk("midrst_de", ifc.Post_DE, 1'b0);
    end
    #2 rst = 1'b0;
    cyc(8'h30, 1'b1, 1'b0); cyc(8'h31, 1'b1, 1'b0);
    idle(2);
    cyc(8'h00, 1'b0, 1'b1);
    check_frame("after_rst", 8'h30, 8'h31, 2, 0, 2);

    // Counter saturation on the narrow instance
    idle(3);
    for (int i = 0; i < 9; i++) cyc(8'hF0, 1'b1, 1'b0);
    idle(2);
    cyc(8'h00, 1'b0, 1'b1);
    check_frame("sat", 8'hF0, 8'hF0, 9, 9, 7);
    chk("sat_bright_narrow", ifs.Frame_Bright_Cnt, STATS_ON ? 32'd7 : 32'd0);

    // Random traffic with periodic Vsync, checked every cycle by the model
    for (int c = 0; c < 500; c++) begin
      drive(8'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 3) != 0), ((c % 47) < 3), 1'($urandom));
    end
    idle(6);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rgb888_to_gray_stats.md
RGB888_TO_GRAY_STATS -- requirements
Module: rgb888_to_gray_stats

Interface
REQ-001 SHALL have parameter BRIGHT_THR, default 8'd200: luma threshold for the bright-pixel count (strictly greater than).
REQ-002 SHALL have parameter CNT_W, default 22: width of the per-frame pixel counters.
REQ-003 SHALL use a single clock and an asynchronous, active-high reset: Pre_clk input 1, pixel clock, all logic on its rising edge; Pre_Rst input 1, asynchronous active-high reset.
REQ-004 Pre_R / Pre_G / Pre_B  input  8 each  RGB888 pixel components.
REQ-005 Pre_DE / Pre_Vsync / Pre_Hsync  input  1 each  video timing; Vsync is active-high.
REQ-006 Post_DE / Post_Vsync / Post_Hsync  output  1 each  timing delayed to align with Post_Gray.
REQ-007 Post_Gray  output  8  luma, which feeds the downstream gamma LUT stage.
REQ-008 Frame_Luma_Min / Frame_Luma_Max  output  8 each  latched per-frame luma extremes.
REQ-009 Frame_Pix_Cnt / Frame_Bright_Cnt  output  CNT_W each  latched per-frame DE-pixel count and bright-pixel count.
REQ-010 Frame_Stat_Valid  output  1  one-cycle pulse when the frame statistics update.

Function
REQ-011 Luma SHALL be (77*R + 150*G + 29*B + 128) >> 8, computed unsigned in 16 bits; no overflow is possible (max 65408).
REQ-012 The pipeline SHALL have 3 registered stages:
- S1: the three products.
- S2: the sum plus 128.
- S3: Post_Gray = sum[15:8].
REQ-013 Latency from Pre_* to Post_* SHALL be exactly 3 cycles for both data and timing; Post_DE/Vsync/Hsync SHALL pass through a matching 3-deep shift register.
REQ-014 Post_Gray SHALL be computed on every cycle regardless of DE; DE gates only the statistics.
REQ-015 A frame boundary SHALL be the rising edge of Post_Vsync, detected against a registered copy of Post_Vsync (Vsync_d).
REQ-016 Running statistics SHALL update on every cycle with Post_DE=1:
- min/max compare against Post_Gray.
- Pixel count +1.
- Bright count +1 when Post_Gray > BRIGHT_THR.
REQ-017 Both counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-018 On a boundary cycle, the block SHALL:
- Copy the running min, max, pixel count and bright count into the Frame_* outputs.
- Pulse Frame_Stat_Valid for one cycle.
- Reinitialise the running values to min=8'hFF, max=8'h00, counts=0.
REQ-019 If Post_DE=1 on a boundary cycle, that pixel SHALL be counted into the new frame, i.e. the running values load from the initial values updated with that pixel.
REQ-020 An empty frame (no DE pixels) SHALL latch min=8'hFF, max=8'h00, Pix_Cnt=0, Bright_Cnt=0.
REQ-021 Frame_* outputs SHALL hold their values between boundaries.
REQ-022 The first boundary after reset SHALL latch whatever accumulated since reset.

Reset
REQ-023 While Pre_Rst=1 the following SHALL be 0: all pipeline registers, Post_Gray, Post_DE, Post_Vsync, Post_Hsync, Vsync_d, Frame_Stat_Valid, Frame_Pix_Cnt, Frame_Bright_Cnt.
REQ-024 While Pre_Rst=1 the block SHALL hold Frame_Luma_Min=8'hFF, Frame_Luma_Max=8'h00, running min=8'hFF, running max=8'h00, running counts=0.
REQ-025 Reset asserted mid-frame SHALL discard partial statistics and produce no Frame_Stat_Valid pulse.
REQ-026 Post_* outputs SHALL return valid data 3 cycles after the first clock edge following reset release.

Configuration
REQ-027 With macro GRAY_FRAME_STATS_EN defined, the statistics logic (REQ-015..REQ-022) SHALL be compiled in.
REQ-028 Without GRAY_FRAME_STATS_EN, the block SHALL:
- Omit the statistics logic.
- Tie Frame_Luma_Min, Frame_Luma_Max, Frame_Pix_Cnt, Frame_Bright_Cnt and Frame_Stat_Valid to constant 0.
- Keep the ports present.
- Leave the pixel path and its latency unchanged.

Verification
REQ-029 Single-component inputs SHALL give the following Post_Gray 3 cycles later:
- R=G=B=8'hFF -> 8'hFF.
- R=8'hFF, G=B=0 -> 8'h4D.
- G=8'hFF only -> 8'h95.
- B=8'hFF only -> 8'h1D.
REQ-030 Pre_DE/Hsync/Vsync toggling pattern 1,0,1,1 SHALL appear identically on Post_* delayed exactly 3 cycles, coincident with the corresponding Post_Gray.
REQ-031 A 4-pixel frame with grays 8'h10, 8'hC8, 8'hFF, 8'h00, followed by a Vsync rising edge, SHALL give Valid pulse=1 for 1 cycle, Min=8'h00, Max=8'hFF, Pix_Cnt=4, Bright_Cnt=1.
REQ-032 Two consecutive Vsync rising edges with no DE between them SHALL latch Min=8'hFF, Max=8'h00, counts=0; a DE pixel of gray 8'h80 on the boundary cycle SHALL appear in the next frame's stats as Min=Max=8'h80, Pix_Cnt=1.
REQ-033 Pre_Rst pulsed mid-frame after 10 DE pixels, then 2 pixels and a Vsync edge, SHALL give Pix_Cnt=2 and no Valid pulse during reset.
REQ-034 With CNT_W=3, 9 DE pixels SHALL give Pix_Cnt=7 (saturated); with GRAY_FRAME_STATS_EN undefined, all Frame_* outputs SHALL stay 0.
